// File: rtl/opentrig_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module      : opentrig_frame_pkg
// Description : Shared definitions for the OpenTrig 128-bit event frame:
//               frame length, framing bytes, field bit positions and the
//               reader FSM state encoding. The SPI slave side uses the same
//               field positions.
// Revision    : 1.0 - initial release
// ============================================================================
package opentrig_frame_pkg;

   localparam int FRAME_BITS = 128;
   localparam logic [7:0] START_BYTE = 8'h7E;
   localparam logic [7:0] END_BYTE   = 8'h7D;

   // Field bit positions within the frame (bit 127 is sent first).
   localparam int START_MSB    = 127;
   localparam int START_LSB    = 120;
   localparam int TRIG_ID_MSB  = 119;
   localparam int TRIG_ID_LSB  = 104;
   localparam int CYCLE_MSB    = 87;
   localparam int CYCLE_LSB    = 40;
   localparam int VETO_BIT     = 39;
   localparam int INT_TRIG_BIT = 38;
   localparam int DATA_MSB     = 31;
   localparam int DATA_LSB     = 8;
   localparam int END_MSB      = 7;
   localparam int END_LSB      = 0;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_LOW   = 3'd2,
      ST_HIGH  = 3'd3,
      ST_HOLD  = 3'd4,
      ST_GAP   = 3'd5
   } reader_state_t;

endpackage : opentrig_frame_pkg
`default_nettype wire

// File: rtl/spi_frame_reader_sync.sv
`default_nettype none
// ============================================================================
// Module      : spi_frame_reader_sync
// Description : Two-flop synchroniser for a single asynchronous input.
// Ports       : clk   - destination clock
//               reset - asynchronous active-high reset (loads RESET_VAL)
//               d     - asynchronous input
//               q     - synchronised output
// Revision    : 1.0 - initial release
// ============================================================================
module spi_frame_reader_sync #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule : spi_frame_reader_sync
`default_nettype wire

// File: rtl/spi_frame_reader.sv
`default_nettype none
// ============================================================================
// Module      : spi_frame_reader
// Description : SPI mode-0 master that reads one 128-bit event frame (MSB
//               first) on an interrupt_n falling edge or a start pulse,
//               checks the 0x7E/0x7D framing bytes and presents the decoded
//               fields with a one-cycle frame_valid / frame_error strobe.
// Ports       : sampling_clk, reset      - clock, async active-high reset
//               interrupt_n, start       - frame requests
//               spi_clk/spi_cs/spi_si    - SPI master outputs
//               spi_so                   - SPI MISO input
//               busy                     - transfer plus CS idle gap active
//               frame_valid/frame_error  - result strobes
//               trigger_id, trigger_cycle, veto, internal_trig, data - fields
// Revision    : 1.0 - initial release
// ============================================================================
module spi_frame_reader
   import opentrig_frame_pkg::*;
#(
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2,
   parameter int CS_IDLE  = 4
) (
   input  logic        sampling_clk,
   input  logic        reset,
   input  logic        interrupt_n,
   input  logic        start,
   output logic        spi_clk,
   output logic        spi_cs,
   output logic        spi_si,
   input  logic        spi_so,
   output logic        busy,
   output logic        frame_valid,
   output logic        frame_error,
   output logic [15:0] trigger_id,
   output logic [47:0] trigger_cycle,
   output logic        veto,
   output logic        internal_trig,
   output logic [23:0] data
);

   localparam int CNT_W = 16;

   reader_state_t         state;
   logic [CNT_W-1:0]      cnt;
   logic [6:0]            bit_cnt;
   logic [FRAME_BITS-1:0] shift;
   logic                  int_sync;
   logic                  int_prev;
   logic                  request;
   logic                  div_last;

   // interrupt_n idles high, so the chain resets high to avoid a false edge.
   spi_frame_reader_sync #(.RESET_VAL(1'b1)) u_int_sync (
      .clk   (sampling_clk),
      .reset (reset),
      .d     (interrupt_n),
      .q     (int_sync)
   );

   // Only a high-to-low transition requests a frame; a held-low line does not.
   assign request  = (int_prev & ~int_sync) | start;
   assign div_last = (cnt == CNT_W'(CLK_DIV - 1));
   assign spi_si   = 1'b0;

   always_ff @(posedge sampling_clk or posedge reset) begin
      if (reset) begin
         state         <= ST_IDLE;
         cnt           <= '0;
         bit_cnt       <= '0;
         shift         <= '0;
         int_prev      <= 1'b1;
         spi_clk       <= 1'b0;
         spi_cs        <= 1'b1;
         busy          <= 1'b0;
         frame_valid   <= 1'b0;
         frame_error   <= 1'b0;
         trigger_id    <= '0;
         trigger_cycle <= '0;
         veto          <= 1'b0;
         internal_trig <= 1'b0;
         data          <= '0;
      end else begin
         int_prev    <= int_sync;
         frame_valid <= 1'b0;
         frame_error <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (request) begin
                  spi_cs <= 1'b0;
                  busy   <= 1'b1;
                  cnt    <= '0;
                  state  <= ST_SETUP;
               end
            end

            ST_SETUP: begin
               if (cnt == CNT_W'(CS_SETUP - 1)) begin
                  cnt     <= '0;
                  bit_cnt <= 7'd127;
                  state   <= ST_LOW;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            ST_LOW: begin
               if (div_last) begin
                  cnt     <= '0;
                  spi_clk <= 1'b1;
                  state   <= ST_HIGH;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            ST_HIGH: begin
               if (div_last) begin
                  // Sample just before the falling edge: the slave changes
                  // spi_so only after the fall, so this is the widest margin.
                  cnt     <= '0;
                  spi_clk <= 1'b0;
                  shift   <= {shift[FRAME_BITS-2:0], spi_so};
                  if (bit_cnt == 7'd0) begin
                     state <= ST_HOLD;
                  end else begin
                     bit_cnt <= bit_cnt - 1'b1;
                     state   <= ST_LOW;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            ST_HOLD: begin
               if (cnt == CNT_W'(CS_HOLD - 1)) begin
                  cnt    <= '0;
                  spi_cs <= 1'b1;
                  state  <= ST_GAP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            ST_GAP: begin
               // First gap cycle is the one in which spi_cs is seen high.
               if (cnt == '0) begin
                  if (shift[START_MSB:START_LSB] == START_BYTE &&
                      shift[END_MSB:END_LSB] == END_BYTE) begin
                     trigger_id    <= shift[TRIG_ID_MSB:TRIG_ID_LSB];
                     trigger_cycle <= shift[CYCLE_MSB:CYCLE_LSB];
                     veto          <= shift[VETO_BIT];
                     internal_trig <= shift[INT_TRIG_BIT];
                     data          <= shift[DATA_MSB:DATA_LSB];
                     frame_valid   <= 1'b1;
                  end else begin
                     frame_error <= 1'b1;
                  end
               end
               if (cnt == CNT_W'(CS_IDLE - 1)) begin
                  cnt   <= '0;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule : spi_frame_reader
`default_nettype wire

// File: tb/tb_spi_frame_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_frame_reader
// Description : Self-checking bench for spi_frame_reader. A behavioural SPI
//               slave serves frames; expected results are queued when a
//               frame is requested and compared when a strobe appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_frame_reader;

   typedef struct {
      logic        err;
      logic [15:0] tid;
      logic [47:0] cyc;
      logic        veto;
      logic        itrig;
      logic [23:0] data;
   } exp_t;

   int checks   = 0;
   int failures = 0;
   exp_t sb_q[$];

   // Model of the field outputs as they should currently be held.
   logic [15:0] m_tid   = '0;
   logic [47:0] m_cyc   = '0;
   logic        m_veto  = 1'b0;
   logic        m_itrig = 1'b0;
   logic [23:0] m_data  = '0;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // ---------------- instance A: default parameters ----------------
   logic        int_n_a = 1'b1, start_a = 1'b0, so_a = 1'b0;
   logic        sck_a, cs_a, si_a, busy_a, fv_a, fe_a, veto_a, itrig_a;
   logic [15:0] tid_a;
   logic [47:0] cyc_a;
   logic [23:0] data_a;

   spi_frame_reader u_dut_a (
      .sampling_clk (clk),     .reset       (rst),
      .interrupt_n  (int_n_a), .start       (start_a),
      .spi_clk      (sck_a),   .spi_cs      (cs_a),
      .spi_si       (si_a),    .spi_so      (so_a),
      .busy         (busy_a),  .frame_valid (fv_a),
      .frame_error  (fe_a),    .trigger_id  (tid_a),
      .trigger_cycle(cyc_a),   .veto        (veto_a),
      .internal_trig(itrig_a), .data        (data_a)
   );

   // ---------------- instance B: CLK_DIV = 2 ----------------
   logic        int_n_b = 1'b1, start_b = 1'b0, so_b = 1'b0;
   logic        sck_b, cs_b, si_b, busy_b, fv_b, fe_b, veto_b, itrig_b;
   logic [15:0] tid_b;
   logic [47:0] cyc_b;
   logic [23:0] data_b;

   spi_frame_reader #(.CLK_DIV(2), .CS_SETUP(2), .CS_HOLD(2), .CS_IDLE(4)) u_dut_b (
      .sampling_clk (clk),     .reset       (rst),
      .interrupt_n  (int_n_b), .start       (start_b),
      .spi_clk      (sck_b),   .spi_cs      (cs_b),
      .spi_si       (si_b),    .spi_so      (so_b),
      .busy         (busy_b),  .frame_valid (fv_b),
      .frame_error  (fe_b),    .trigger_id  (tid_b),
      .trigger_cycle(cyc_b),   .veto        (veto_b),
      .internal_trig(itrig_b), .data        (data_b)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] mk(input logic [7:0] sb, input logic [15:0] tid,
                                       input logic [47:0] cyc, input logic v,
                                       input logic it, input logic [23:0] d,
                                       input logic [7:0] eb);
      // Reserved fields carry non-zero junk that must be ignored.
      return {sb, tid, 16'hC3A5, cyc, v, it, 6'b101101, d, eb};
   endfunction

   task automatic push_good(input logic [15:0] tid, input logic [47:0] cyc,
                            input logic v, input logic it, input logic [23:0] d);
      exp_t e;
      e.err = 1'b0; e.tid = tid; e.cyc = cyc; e.veto = v; e.itrig = it; e.data = d;
      sb_q.push_back(e);
      m_tid = tid; m_cyc = cyc; m_veto = v; m_itrig = it; m_data = d;
   endtask

   task automatic push_err();
      exp_t e;
      e.err = 1'b1; e.tid = m_tid; e.cyc = m_cyc; e.veto = m_veto;
      e.itrig = m_itrig; e.data = m_data;
      sb_q.push_back(e);
   endtask

   // ---------------- slave models (mode 0, shift on falling edge) ----------------
   logic [127:0] frame_a = '0, frame_b = '0;
   int idx_a = 0, idx_b = 0;

   always @(negedge cs_a) begin idx_a = 127; so_a = frame_a[127]; end
   always @(negedge sck_a) if (cs_a === 1'b0) begin
      idx_a--;
      if (idx_a >= 0) so_a = frame_a[idx_a];
   end
   always @(negedge cs_b) begin idx_b = 127; so_b = frame_b[127]; end
   always @(negedge sck_b) if (cs_b === 1'b0) begin
      idx_b--;
      if (idx_b >= 0) so_b = frame_b[idx_b];
   end

   // ---------------- monitors ----------------
   int rise_a = 0, rise_b = 0, csfall_a = 0, csfall_b = 0;
   int low_a = 0, low_b = 0, gap_a = 0, run_b = 0, runs_b = 0, badrun_b = 0;
   int fv_cnt_b = 0, fe_cnt_b = 0;
   logic si_seen_a = 1'b0, si_seen_b = 1'b0;

   always @(posedge sck_a) rise_a++;
   always @(posedge sck_b) rise_b++;
   always @(negedge cs_a) csfall_a++;
   always @(negedge cs_b) csfall_b++;

   always @(negedge clk) begin
      if (cs_a === 1'b0) low_a++;
      if (cs_b === 1'b0) low_b++;
      if (cs_a === 1'b1 && busy_a === 1'b1) gap_a++;
      if (si_a !== 1'b0) si_seen_a = 1'b1;
      if (si_b !== 1'b0) si_seen_b = 1'b1;
      if (sck_b === 1'b1) run_b++;
      else if (run_b != 0) begin
         runs_b++;
         if (run_b != 2) badrun_b++;
         run_b = 0;
      end
      if (fv_b === 1'b1) fv_cnt_b++;
      if (fe_b === 1'b1) fe_cnt_b++;

      if (fv_a === 1'b1 || fe_a === 1'b1) begin
         chk("strobe_exclusive", {63'd0, fv_a & fe_a}, 64'd0);
         checks++;
         assert (sb_q.size() != 0) else begin
            failures++;
            $error("FAIL unexpected_strobe observed=valid%0b/error%0b expected=no strobe", fv_a, fe_a);
         end
         if (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("strobe_kind_error", {63'd0, fe_a}, {63'd0, e.err});
            chk("trigger_id", {48'd0, tid_a}, {48'd0, e.tid});
            chk("trigger_cycle", {16'd0, cyc_a}, {16'd0, e.cyc});
            chk("veto", {63'd0, veto_a}, {63'd0, e.veto});
            chk("internal_trig", {63'd0, itrig_a}, {63'd0, e.itrig});
            chk("data", {40'd0, data_a}, {40'd0, e.data});
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start_a();
      @(posedge clk); #1 start_a = 1'b1;
      @(posedge clk); #1 start_a = 1'b0;
   endtask

   // Waits for a whole A transfer (busy rise then fall), bounded.
   task automatic wait_done_a(input string tag);
      int n;
      logic seen;
      n = 0; seen = 1'b0;
      while (n < 3000 && !(seen && busy_a === 1'b0)) begin
         @(negedge clk);
         if (busy_a === 1'b1) seen = 1'b1;
         n++;
      end
      chk(tag, {63'd0, seen && busy_a === 1'b0}, 64'd1);
      cycles(3);
      chk({tag, "_sb_drained"}, 64'(sb_q.size()), 64'd0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int n, f0;

      // Reset state
      cycles(3);
      chk("rst_cs", {63'd0, cs_a}, 64'd1);
      chk("rst_sck", {63'd0, sck_a}, 64'd0);
      chk("rst_si", {63'd0, si_a}, 64'd0);
      chk("rst_busy", {63'd0, busy_a}, 64'd0);
      chk("rst_strobes", {62'd0, fv_a, fe_a}, 64'd0);
      chk("rst_fields", {tid_a, cyc_a}, 64'd0);
      chk("rst_data", {39'd0, veto_a, itrig_a, data_a}, 64'd0);
      @(posedge clk); #1 rst = 1'b0;
      cycles(5);

      // Frame 1 via interrupt_n falling edge
      frame_a = {8'h7E, 16'h0012, 16'h0000, 48'h000000ABCDEF, 8'h80, 24'hA5B6C7, 8'h7D};
      push_good(16'h0012, 48'h000000ABCDEF, 1'b1, 1'b0, 24'hA5B6C7);
      rise_a = 0; low_a = 0; gap_a = 0;
      @(posedge clk); #1 int_n_a = 1'b0;
      wait_done_a("frame1_done");
      chk("frame1_rises", 64'(rise_a), 64'd128);
      chk("frame1_cs_low", 64'(low_a), 64'd1028);
      chk("frame1_gap", 64'(gap_a), 64'd4);
      @(posedge clk); #1 int_n_a = 1'b1;
      cycles(10);

      // Bad start byte, then bad end byte: fields must hold
      frame_a = mk(8'h7F, 16'hBEEF, 48'h1234_5678_9ABC, 1'b0, 1'b1, 24'h111111, 8'h7D);
      push_err();
      pulse_start_a();
      wait_done_a("bad_start_done");
      frame_a = mk(8'h7E, 16'hDEAD, 48'h0000_0000_0001, 1'b0, 1'b1, 24'h222222, 8'h7C);
      push_err();
      pulse_start_a();
      wait_done_a("bad_end_done");
      chk("held_tid", {48'd0, tid_a}, 64'h0012);
      chk("held_data", {40'd0, data_a}, 64'hA5B6C7);

      // Requests while busy are dropped
      frame_a = mk(8'h7E, 16'h4321, 48'hFEDC_BA98_7654, 1'b0, 1'b1, 24'h0F0F0F, 8'h7D);
      push_good(16'h4321, 48'hFEDC_BA98_7654, 1'b0, 1'b1, 24'h0F0F0F);
      f0 = csfall_a; gap_a = 0;
      pulse_start_a();
      cycles(200);
      pulse_start_a();
      @(posedge clk); #1 int_n_a = 1'b0;
      wait_done_a("busy_req_done");
      chk("busy_req_one_frame", 64'(csfall_a - f0), 64'd1);
      chk("busy_gap", 64'(gap_a), 64'd4);
      @(posedge clk); #1 int_n_a = 1'b1;
      cycles(20);
      chk("no_extra_frame", 64'(csfall_a - f0), 64'd1);

      // Reset after 60 bits
      frame_a = mk(8'h7E, 16'h5555, 48'h0000_0000_5555, 1'b1, 1'b1, 24'h555555, 8'h7D);
      rise_a = 0;
      pulse_start_a();
      n = 0;
      while (rise_a < 60 && n < 2000) begin @(negedge clk); n++; end
      chk("reached_60_bits", 64'(rise_a), 64'd60);
      cycles(1);
      rst = 1'b1;
      #1;
      chk("midrst_cs", {63'd0, cs_a}, 64'd1);
      chk("midrst_sck", {63'd0, sck_a}, 64'd0);
      chk("midrst_busy", {63'd0, busy_a}, 64'd0);
      m_tid = '0; m_cyc = '0; m_veto = 1'b0; m_itrig = 1'b0; m_data = '0;
      cycles(3);
      @(posedge clk); #1 rst = 1'b0;
      cycles(30);
      chk("midrst_fields", {tid_a, cyc_a}, 64'd0);
      frame_a = mk(8'h7E, 16'hA0A0, 48'h0A0A_0A0A_0A0A, 1'b1, 1'b0, 24'hC0FFEE, 8'h7D);
      push_good(16'hA0A0, 48'h0A0A_0A0A_0A0A, 1'b1, 1'b0, 24'hC0FFEE);
      rise_a = 0;
      pulse_start_a();
      wait_done_a("post_rst_done");
      chk("post_rst_rises", 64'(rise_a), 64'd128);

      // interrupt_n held low does not retrigger
      frame_a = mk(8'h7E, 16'h0001, 48'h0000_0000_0002, 1'b0, 1'b0, 24'h000003, 8'h7D);
      push_good(16'h0001, 48'h0000_0000_0002, 1'b0, 1'b0, 24'h000003);
      f0 = csfall_a;
      @(posedge clk); #1 int_n_a = 1'b0;
      wait_done_a("held_low_done");
      cycles(1000);
      chk("held_low_one_frame", 64'(csfall_a - f0), 64'd1);
      frame_a = mk(8'h7E, 16'h0002, 48'h0000_0000_0004, 1'b1, 1'b1, 24'h000006, 8'h7D);
      push_good(16'h0002, 48'h0000_0000_0004, 1'b1, 1'b1, 24'h000006);
      @(posedge clk); #1 int_n_a = 1'b1;
      cycles(6);
      @(posedge clk); #1 int_n_a = 1'b0;
      wait_done_a("refall_done");
      chk("refall_two_frames", 64'(csfall_a - f0), 64'd2);
      chk("si_a_zero", {63'd0, si_seen_a}, 64'd0);

      // CLK_DIV = 2 instance
      frame_b = mk(8'h7E, 16'h7777, 48'h0123_4567_89AB, 1'b1, 1'b0, 24'h89ABCD, 8'h7D);
      rise_b = 0; low_b = 0;
      @(posedge clk); #1 start_b = 1'b1;
      @(posedge clk); #1 start_b = 1'b0;
      n = 0;
      while (n < 1500 && !(csfall_b == 1 && busy_b === 1'b0)) begin @(negedge clk); n++; end
      chk("b_done", {63'd0, busy_b === 1'b0 && csfall_b == 1}, 64'd1);
      cycles(3);
      chk("b_cs_low", 64'(low_b), 64'd516);
      chk("b_rises", 64'(rise_b), 64'd128);
      chk("b_high_runs", 64'(runs_b), 64'd128);
      chk("b_bad_high_width", 64'(badrun_b), 64'd0);
      chk("b_si_zero", {63'd0, si_seen_b}, 64'd0);
      chk("b_valid_count", 64'(fv_cnt_b), 64'd1);
      chk("b_error_count", 64'(fe_cnt_b), 64'd0);
      chk("b_tid", {48'd0, tid_b}, 64'h7777);
      chk("b_cycle", {16'd0, cyc_b}, 64'h0123_4567_89AB);
      chk("b_data", {39'd0, veto_b, itrig_b, data_b}, {39'd0, 1'b1, 1'b0, 24'h89ABCD});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_spi_frame_reader
`default_nettype wire
